tx_controller: RTL and testbench

//  FSM that sequences the UART transmit datapath (PISO shifter, parity generator, 4:1 output mux).

---
 rtl/tx_controller.sv | 154 +++++++++++++++
 tb/tb_tx_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_controller.sv
// tx_controller
//   Sequencing FSM for a UART transmit datapath (PISO shifter, parity
//   generator, 4:1 output mux). Accepts one byte per valid/ready handshake,
//   generates the baud timing and drives the datapath strobes and mux selects.
//   Only one frame is in flight at a time.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit period (>= 2)
//   PARITY_EN     1: parity bit follows D7, 0: no parity bit
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   tx_valid    in   host presents a byte on the datapath data_in
//   tx_ready    out  idle, a byte can be accepted
//   counter     in   PISO shift count (0 after load, +1 per shift)
//   load        out  PISO/parity parallel load strobe (accept cycle only)
//   par_signal  out  parity generator capture strobe (accept cycle only)
//   shift       out  PISO shift strobe, last cycle of every data bit
//   selA/selB   out  output mux select {selA,selB}:
//                    00 start, 01 data, 10 parity, 11 stop/idle
//   start_bit   out  start level (0)
//   stop_bit    out  stop/idle level (1)
//   tx_busy     out  frame in progress
//   tx_done     out  one-cycle pulse on the last cycle of the stop bit
//
// States
//   state    | meaning
//   S_IDLE   | line high, tx_ready=1, waiting for tx_valid
//   S_START  | start bit, line low for one bit period
//   S_DATA   | data bits D0..D7, shift at the end of each bit
//   S_PARITY | parity bit (only when PARITY_EN=1)
//   S_STOP   | stop bit, tx_done on its last cycle
module tx_controller #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [3:0] counter,
  output logic       load,
  output logic       par_signal,
  output logic       shift,
  output logic       selA,
  output logic       selB,
  output logic       start_bit,
  output logic       stop_bit,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BC_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [1:0]      sel_q, sel_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            bit_end;
  logic            accept;
  logic            data_last;

  assign bit_end = (bc_q == BC_LAST);
  assign accept  = tx_valid & ready_q;
  // A counter beyond 7 is a datapath fault; end the data phase anyway so the
  // frame cannot run on forever.
  assign data_last = (counter >= 4'd7);

  always_comb begin
    state_d = state_q;
    bc_d    = bit_end ? '0 : bc_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        bc_d = '0;
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && data_last) state_d = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        bc_d    = '0;
      end
    endcase

    // Mux select and handshake flags are registered alongside the state so
    // they change on the same edge as the state they describe.
    unique case (state_d)
      S_START:  sel_d = SEL_START;
      S_DATA:   sel_d = SEL_DATA;
      S_PARITY: sel_d = SEL_PARITY;
      default:  sel_d = SEL_STOP;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
      sel_q   <= SEL_STOP;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Strobes are decoded straight from the registered state so the datapath
  // acts on the same edge that the FSM advances; reset suppresses them.
  assign load       = accept & ~reset;
  assign par_signal = accept & ~reset;
  assign shift      = (state_q == S_DATA) & bit_end & ~reset;
  assign tx_done    = (state_q == S_STOP) & bit_end & ~reset;

  assign tx_ready  = ready_q;
  assign tx_busy   = busy_q;
  assign selA      = sel_q[1];
  assign selB      = sel_q[0];
  assign start_bit = 1'b0;
  assign stop_bit  = 1'b1;

endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller: instance 0 without parity, instance 1 with parity,
// both at 16 clocks per bit. A small PISO/parity model closes the loop on the
// counter input and reconstructs the serial line from the mux selects.
module tb_tx_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [2];
  logic       valid   [2];
  logic [3:0] cnt_in  [2];
  logic       ready   [2];
  logic       load    [2];
  logic       par_s   [2];
  logic       shift   [2];
  logic       selA    [2];
  logic       selB    [2];
  logic       sb      [2];
  logic       stb     [2];
  logic       busy    [2];
  logic       done    [2];
  logic [1:0] selv    [2];

  logic [3:0] cnt     [2];
  logic [7:0] shreg   [2];
  logic [7:0] byte_q  [2];
  logic [7:0] data_in [2];
  logic       fault   [2];

  int checks = 0;
  int errors = 0;

  tx_controller #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0)) u_np (
    .clock(clk), .reset(rst[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
    .counter(cnt_in[0]), .load(load[0]), .par_signal(par_s[0]), .shift(shift[0]),
    .selA(selA[0]), .selB(selB[0]), .start_bit(sb[0]), .stop_bit(stb[0]),
    .tx_busy(busy[0]), .tx_done(done[0]));

  tx_controller #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1)) u_p (
    .clock(clk), .reset(rst[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
    .counter(cnt_in[1]), .load(load[1]), .par_signal(par_s[1]), .shift(shift[1]),
    .selA(selA[1]), .selB(selB[1]), .start_bit(sb[1]), .stop_bit(stb[1]),
    .tx_busy(busy[1]), .tx_done(done[1]));

  assign selv[0]   = {selA[0], selB[0]};
  assign selv[1]   = {selA[1], selB[1]};
  assign cnt_in[0] = fault[0] ? 4'd12 : cnt[0];
  assign cnt_in[1] = fault[1] ? 4'd12 : cnt[1];

  // Datapath model: PISO with bit counter plus captured byte for parity.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        cnt[i]    <= 4'd0;
        shreg[i]  <= 8'h00;
        byte_q[i] <= 8'h00;
      end else if (load[i]) begin
        cnt[i]    <= 4'd0;
        shreg[i]  <= data_in[i];
        byte_q[i] <= data_in[i];
      end else if (shift[i]) begin
        cnt[i]    <= cnt[i] + 4'd1;
        shreg[i]  <= shreg[i] >> 1;
      end
    end
  end

  function automatic logic line_of(input int i);
    case (selv[i])
      2'b00:   return sb[i];
      2'b01:   return shreg[i][0];
      2'b10:   return ^byte_q[i];
      default: return stb[i];
    endcase
  endfunction

  // Expected serial bit idx of a frame: start, D0..D7, [parity], stop.
  function automatic logic exp_bit(input int i, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && i == 1) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         pe;
    int         off;
    logic [1:0] sel;
    logic       sh;
    logic       dn;
    logic       rd;
    logic       bs;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int pe, input int off, input logic [1:0] sel,
                              input logic sh, input logic dn, input logic rd, input logic bs);
    vec_t v;
    v.pe = pe; v.off = off; v.sel = sel; v.sh = sh; v.dn = dn; v.rd = rd; v.bs = bs;
    tbl.push_back(v);
  endfunction

  // Offsets count cycles after the accept edge: 1 = first START cycle.
  task automatic run_frame(input int i, input logic [7:0] b, input int pulse_off);
    int L;
    int nshift, ndone, nload, last_sh;
    bit saw_par;
    L = (i == 1) ? 176 : 160;
    nshift = 0; ndone = 0; nload = 0; last_sh = -1; saw_par = 0;
    data_in[i] = b;
    valid[i]   = 1'b1;
    #1;
    chk("load_at_accept", load[i], 1);
    chk("par_at_accept", par_s[i], 1);
    @(negedge clk);
    valid[i] = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      if (k == pulse_off) begin
        valid[i] = 1'b1;
        #1;
        chk("load_while_busy", load[i], 0);
        chk("ready_while_busy", ready[i], 0);
      end
      if (load[i]) nload++;
      if (shift[i]) begin
        nshift++;
        if (last_sh >= 0) chk("shift_gap", k - last_sh, 16);
        last_sh = k;
      end
      if (done[i]) begin
        ndone++;
        chk("done_offset", k, L);
      end
      if (selv[i] == 2'b10) saw_par = 1'b1;
      foreach (tbl[j]) begin
        if (tbl[j].pe == i && tbl[j].off == k) begin
          chk($sformatf("sel@%0d", k), selv[i], tbl[j].sel);
          chk($sformatf("shift@%0d", k), shift[i], tbl[j].sh);
          chk($sformatf("done@%0d", k), done[i], tbl[j].dn);
          chk($sformatf("ready@%0d", k), ready[i], tbl[j].rd);
          chk($sformatf("busy@%0d", k), busy[i], tbl[j].bs);
        end
      end
      if (k <= L && ((k - 1) % 16) == 8)
        chk($sformatf("line_bit%0d", (k - 1) / 16), line_of(i), exp_bit(i, b, (k - 1) / 16));
      @(negedge clk);
      valid[i] = 1'b0;
    end
    chk("shift_count", nshift, 8);
    chk("done_count", ndone, 1);
    chk("extra_loads", nload, 0);
    chk("parity_seen", saw_par, (i == 1) ? 1 : 0);
  endtask

  initial begin
    int nl;
    int lpos[$];

    add(1,   1, 2'b00, 0, 0, 0, 1);
    add(1,  16, 2'b00, 0, 0, 0, 1);
    add(1,  17, 2'b01, 0, 0, 0, 1);
    add(1,  31, 2'b01, 0, 0, 0, 1);
    add(1,  32, 2'b01, 1, 0, 0, 1);
    add(1,  48, 2'b01, 1, 0, 0, 1);
    add(1, 144, 2'b01, 1, 0, 0, 1);
    add(1, 145, 2'b10, 0, 0, 0, 1);
    add(1, 160, 2'b10, 0, 0, 0, 1);
    add(1, 161, 2'b11, 0, 0, 0, 1);
    add(1, 175, 2'b11, 0, 0, 0, 1);
    add(1, 176, 2'b11, 0, 1, 0, 1);
    add(1, 177, 2'b11, 0, 0, 1, 0);
    add(0,   1, 2'b00, 0, 0, 0, 1);
    add(0,  16, 2'b00, 0, 0, 0, 1);
    add(0,  17, 2'b01, 0, 0, 0, 1);
    add(0,  32, 2'b01, 1, 0, 0, 1);
    add(0, 144, 2'b01, 1, 0, 0, 1);
    add(0, 145, 2'b11, 0, 0, 0, 1);
    add(0, 159, 2'b11, 0, 0, 0, 1);
    add(0, 160, 2'b11, 0, 1, 0, 1);
    add(0, 161, 2'b11, 0, 0, 1, 0);

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; data_in[i] = 8'h00; fault[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++) begin
        chk("idle_ready", ready[i], 1);
        chk("idle_sel", selv[i], 2'b11);
        chk("idle_load", load[i], 0);
        chk("idle_shift", shift[i], 0);
        chk("idle_done", done[i], 0);
        if (c == 0) chk("idle_busy", busy[i], 0);
      end
      @(negedge clk);
    end

    run_frame(1, 8'hA5, 0);
    run_frame(0, 8'h00, 0);
    run_frame(1, 8'h5A, 50);
    run_frame(0, 8'hC3, 0);

    // Reset wins over an accept in the same cycle.
    rst[1] = 1'b1; valid[1] = 1'b1;
    #1;
    chk("rst_accept_load", load[1], 0);
    @(negedge clk);
    rst[1] = 1'b0; valid[1] = 1'b0;
    chk("rst_accept_ready", ready[1], 1);
    chk("rst_accept_busy", busy[1], 0);
    @(negedge clk);
    chk("rst_accept_stay_idle", busy[1], 0);

    // Reset mid-frame at bc=5 of data bit 3.
    data_in[1] = 8'h3C; valid[1] = 1'b1;
    @(negedge clk);
    valid[1] = 1'b0;
    for (int k = 1; k < 70; k++) @(negedge clk);
    chk("midrst_in_data", selv[1], 2'b01);
    rst[1] = 1'b1;
    #1;
    chk("midrst_no_shift", shift[1], 0);
    chk("midrst_no_done", done[1], 0);
    @(negedge clk);
    rst[1] = 1'b0;
    chk("midrst_sel", selv[1], 2'b11);
    chk("midrst_ready", ready[1], 1);
    chk("midrst_busy", busy[1], 0);
    chk("midrst_done", done[1], 0);
    nl = 0;
    for (int c = 0; c < 200; c++) begin
      if (done[1] || shift[1]) nl++;
      @(negedge clk);
    end
    chk("midrst_quiet_after", nl, 0);

    // Counter fault (>7) at the first data bit end: go straight to parity.
    data_in[1] = 8'h0F; valid[1] = 1'b1;
    @(negedge clk);
    valid[1] = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      if (k == 17) fault[1] = 1'b1;
      if (k == 32) chk("fault_shift", shift[1], 1);
      if (k == 33) chk("fault_sel_parity", selv[1], 2'b10);
      if (k == 49) chk("fault_sel_stop", selv[1], 2'b11);
      if (k == 63) chk("fault_no_early_done", done[1], 0);
      if (k == 64) chk("fault_done", done[1], 1);
      if (k == 65) chk("fault_ready", ready[1], 1);
      @(negedge clk);
    end
    fault[1] = 1'b0;

    // tx_valid held high: one load per frame, accepts 177 cycles apart.
    valid[1] = 1'b1; data_in[1] = 8'h81;
    for (int t = 0; t < 360; t++) begin
      #1;
      if (load[1]) lpos.push_back(t);
      @(negedge clk);
    end
    valid[1] = 1'b0;
    chk("held_load_count", lpos.size(), 3);
    if (lpos.size() == 3) begin
      chk("held_first", lpos[0], 0);
      chk("held_gap1", lpos[1] - lpos[0], 177);
      chk("held_gap2", lpos[2] - lpos[1], 177);
    end
    repeat (180) @(negedge clk);
    chk("held_end_idle", ready[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
